// File: rtl/mem_sweep_ctrl.sv
// Memory sweep engine: walks Count words from BaseAddr at a fixed byte stride, checksumming reads.
// Optional fill mode (incrementing pattern writes) is enabled by defining MEM_SWEEP_FILL_EN.
module mem_sweep_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int STRIDE     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [CNT_W-1:0]  Count,
  input  logic [DATA_W-1:0] Seed,
  output logic [ADDR_W-1:0] raddress,
  output logic [ADDR_W-1:0] waddress,
  output logic [DATA_W-1:0] Datain,
  output logic              Wr,
  input  logic [DATA_W-1:0] Dataout,
  output logic              RdValid,
  output logic [DATA_W-1:0] RdData,
  output logic [DATA_W-1:0] Checksum,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_next;
  logic                    start_ok, start_fill, fill_mode;
  logic                    issue, last_word, drain_done, capture_en;
  logic [CNT_W-1:0]        remaining;
  logic [RD_LATENCY-1:0]   pipe;
  logic [ADDR_W-1:0]       raddr_q;

  assign start_ok  = (state == IDLE) && Start;
  assign last_word = (remaining == CNT_W'(1));

`ifdef MEM_SWEEP_FILL_EN
  logic              mode_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] fill_val;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q   <= 1'b0;
      waddr_q  <= '0;
      fill_val <= '0;
    end else if (start_ok) begin
      mode_q <= Mode;
      if (Mode && (Count != '0)) begin
        waddr_q  <= BaseAddr;
        fill_val <= Seed;
      end
    end else if ((state == ISSUE) && mode_q && !last_word) begin
      waddr_q  <= waddr_q + ADDR_W'(STRIDE);
      fill_val <= fill_val + DATA_W'(1);
    end
  end

  assign fill_mode  = mode_q;
  assign start_fill = Mode;
  assign waddress   = waddr_q;
  assign Datain     = fill_val;
`else
  logic unused_fill_inputs;
  assign unused_fill_inputs = ^{Mode, Seed};
  assign fill_mode  = 1'b0;
  assign start_fill = 1'b0;
  assign waddress   = '0;
  assign Datain     = '0;
`endif

  // The last pipe stage is RdValid itself, so data is captured one stage earlier.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign capture_en = issue;
      assign drain_done = 1'b1;
    end else begin : g_latn
      assign capture_en = pipe[RD_LATENCY-2];
      assign drain_done = (pipe[RD_LATENCY-2:0] == '0);
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = (Count == '0) ? DONE : ISSUE;
      ISSUE:   if (last_word) state_next = fill_mode ? DONE : DRAIN;
      DRAIN:   if (drain_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state != IDLE);
    Done  = (state == DONE);
    Wr    = (state == ISSUE) && fill_mode;
    issue = (state == ISSUE) && !fill_mode;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      remaining <= '0;
      raddr_q   <= '0;
    end else if (start_ok) begin
      remaining <= Count;
      if (!start_fill && (Count != '0)) raddr_q <= BaseAddr;
    end else if (state == ISSUE) begin
      remaining <= remaining - CNT_W'(1);
      if (issue && !last_word) raddr_q <= raddr_q + ADDR_W'(STRIDE);
    end
  end

  assign raddress = raddr_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pipe     <= '0;
      RdData   <= '0;
      Checksum <= '0;
    end else begin
      pipe[0] <= issue;
      for (int k = 1; k < RD_LATENCY; k++) pipe[k] <= pipe[k-1];
      if (capture_en) RdData <= Dataout;
      if (start_ok && !start_fill) Checksum <= '0;
      else if (RdValid)            Checksum <= Checksum + RdData;
    end
  end

  assign RdValid = pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Self-checking bench for mem_sweep_ctrl: a table of sweeps on a latency-1 instance
// plus hand-written sequences for latency 3, ignored Start, and mid-sweep reset.
module tb_mem_sweep_ctrl;

`ifdef MEM_SWEEP_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, start1, start3, mode_i, preload;
  logic [31:0] base_i, seed_i;
  logic [15:0] count_i;

  logic [31:0] raddr1, waddr1, datain1, dout1, rddata1, csum1;
  logic        wr1, rdvalid1, busy1, done1;
  logic [31:0] raddr3, waddr3, datain3, dout3, rddata3, csum3;
  logic        wr3, rdvalid3, busy3, done3;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] exp_mem [256];
  logic [31:0] a1, a2;

  int checks = 0;
  int errors = 0;

  mem_sweep_ctrl #(.RD_LATENCY(1)) dut1 (
    .Clk(clk), .Reset(rst1), .Start(start1), .Mode(mode_i), .BaseAddr(base_i),
    .Count(count_i), .Seed(seed_i), .raddress(raddr1), .waddress(waddr1),
    .Datain(datain1), .Wr(wr1), .Dataout(dout1), .RdValid(rdvalid1),
    .RdData(rddata1), .Checksum(csum1), .Busy(busy1), .Done(done1)
  );

  mem_sweep_ctrl #(.RD_LATENCY(3)) dut3 (
    .Clk(clk), .Reset(rst3), .Start(start3), .Mode(mode_i), .BaseAddr(base_i),
    .Count(count_i), .Seed(seed_i), .raddress(raddr3), .waddress(waddr3),
    .Datain(datain3), .Wr(wr3), .Dataout(dout3), .RdValid(rdvalid3),
    .RdData(rddata3), .Checksum(csum3), .Busy(busy3), .Done(done3)
  );

  // Latency-1 memory: combinational read, registered write, preloaded word k = k+1
  assign dout1 = mem1[raddr1[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem1[k] <= 32'(k + 1);
    end else if (wr1) begin
      mem1[waddr1[9:2]] <= datain1;
    end
  end

  // Latency-3 memory: address delayed two cycles so data is captured on the third edge
  initial for (int k = 0; k < 256; k++) mem3[k] = 32'(k + 1);
  always @(posedge clk) begin
    a1 <= raddr3;
    a2 <= a1;
  end
  assign dout3 = mem3[a2[9:2]];

  typedef struct {
    logic        mode;
    logic [31:0] base;
    logic [15:0] cnt;
    logic [31:0] seed;
    int          exp_done;
    int          exp_valid;
    int          exp_wr;
    logic [31:0] exp_sum;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int done_at, output int nvalid,
                               output int nwr, output logic [31:0] sum);
    logic [31:0] ea;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy1), 32'd0);
    mode_i  = v.mode;
    base_i  = v.base;
    count_i = v.cnt;
    seed_i  = v.seed;
    start1  = 1'b1;
    done_at = -1;
    nvalid  = 0;
    nwr     = 0;
    sum     = '0;
    for (int cyc = 1; cyc <= int'(v.cnt) + 10; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (cyc == 1) checkOutput("busy_rise", 32'(busy1), 32'd1);
      if (cyc <= int'(v.cnt)) begin
        if (FILL_EN && v.mode) begin
          checkOutput("waddress", waddr1, v.base + 32'((cyc - 1) * 4));
          checkOutput("datain", datain1, v.seed + 32'(cyc - 1));
        end else begin
          checkOutput("raddress", raddr1, v.base + 32'((cyc - 1) * 4));
        end
      end
      if (rdvalid1) begin
        ea = v.base + 32'(nvalid * 4);
        checkOutput("rddata", rddata1, exp_mem[ea[9:2]]);
        nvalid++;
      end
      if (wr1) nwr++;
      if (done1) begin
        done_at = cyc;
        sum     = csum1;
        break;
      end
    end
  endtask

  vec_t        vecs [7];
  int          done_at, nvalid, nwr, ndone;
  logic [31:0] sum, vmask, ea;

  initial begin
    for (int k = 0; k < 256; k++) exp_mem[k] = 32'(k + 1);
    vecs[0] = '{1'b0, 32'h0, 16'd17, 32'h0, 19, 17, 0, 32'd153};
    vecs[1] = FILL_EN ? '{1'b1, 32'h100, 16'd4, 32'hA0, 5, 0, 4, 32'd153}
                      : '{1'b1, 32'h100, 16'd4, 32'hA0, 6, 4, 0, 32'd266};
    vecs[2] = FILL_EN ? '{1'b0, 32'h100, 16'd4, 32'h0, 6, 4, 0, 32'h286}
                      : '{1'b0, 32'h100, 16'd4, 32'h0, 6, 4, 0, 32'd266};
    vecs[3] = '{1'b0, 32'h0, 16'd0, 32'h0, 1, 0, 0, 32'd0};
    vecs[4] = '{1'b0, 32'hFFFF_FFF8, 16'd4, 32'h0, 6, 4, 0, 32'd514};
    vecs[5] = FILL_EN ? '{1'b1, 32'h0, 16'd0, 32'h55, 1, 0, 0, 32'd514}
                      : '{1'b1, 32'h0, 16'd0, 32'h55, 1, 0, 0, 32'd0};
    vecs[6] = '{1'b0, 32'h40, 16'd3, 32'h0, 5, 3, 0, 32'd54};

    rst1 = 1'b1; rst3 = 1'b1; preload = 1'b1;
    start1 = 1'b0; start3 = 1'b0; mode_i = 1'b0;
    base_i = '0; count_i = '0; seed_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_raddress", raddr1, 32'd0);
    checkOutput("rst_waddress", waddr1, 32'd0);
    checkOutput("rst_datain", datain1, 32'd0);
    checkOutput("rst_wr", 32'(wr1), 32'd0);
    checkOutput("rst_rdvalid", 32'(rdvalid1), 32'd0);
    checkOutput("rst_rddata", rddata1, 32'd0);
    checkOutput("rst_checksum", csum1, 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_done", 32'(done1), 32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    rst1 = 1'b0; rst3 = 1'b0; preload = 1'b0;

    // Table of back-to-back sweeps on the latency-1 instance
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], done_at, nvalid, nwr, sum);
      checkOutput($sformatf("v%0d_done_cycle", i), 32'(done_at), 32'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d_rdvalid_count", i), 32'(nvalid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_wr_count", i), 32'(nwr), 32'(vecs[i].exp_wr));
      checkOutput($sformatf("v%0d_checksum", i), sum, vecs[i].exp_sum);
      if (FILL_EN && vecs[i].mode) begin
        for (int w = 0; w < int'(vecs[i].cnt); w++) begin
          ea = vecs[i].base + 32'(w * 4);
          exp_mem[ea[9:2]] = vecs[i].seed + 32'(w);
        end
      end
    end
    @(negedge clk);
    checkOutput("busy_fall", 32'(busy1), 32'd0);
    checkOutput("done_single", 32'(done1), 32'd0);

    // Latency 3, Count 5, with an ignored Start and changed inputs mid-sweep
    mode_i = 1'b0; base_i = 32'h0; count_i = 16'd5; start3 = 1'b1;
    vmask = '0; done_at = -1; ndone = 0; sum = '0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (rdvalid3) vmask[cyc] = 1'b1;
      if (done3) begin
        ndone++;
        if (done_at < 0) begin
          done_at = cyc;
          sum     = csum3;
        end
      end
      if (cyc == 3) begin
        base_i = 32'h80; count_i = 16'd2; start3 = 1'b1;
      end
    end
    checkOutput("lat3_valid_mask", vmask, 32'h0000_01F0);
    checkOutput("lat3_done_cycle", 32'(done_at), 32'd9);
    checkOutput("lat3_done_count", 32'(ndone), 32'd1);
    checkOutput("lat3_checksum", sum, 32'd15);
    checkOutput("lat3_last_rddata", rddata3, 32'd5);
    checkOutput("lat3_idle", 32'(busy3), 32'd0);

    // Reset at E+3 of a 10-word read on the latency-1 instance
    @(negedge clk);
    mode_i = 1'b0; base_i = 32'h0; count_i = 16'd10; start1 = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    checkOutput("mid_rst_raddress", raddr1, 32'd0);
    checkOutput("mid_rst_rdvalid", 32'(rdvalid1), 32'd0);
    checkOutput("mid_rst_rddata", rddata1, 32'd0);
    checkOutput("mid_rst_checksum", csum1, 32'd0);
    checkOutput("mid_rst_busy", 32'(busy1), 32'd0);
    checkOutput("mid_rst_done", 32'(done1), 32'd0);
    nvalid = 0; ndone = 0;
    for (int cyc = 5; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (rdvalid1) nvalid++;
      if (done1) ndone++;
    end
    checkOutput("post_rst_rdvalid", 32'(nvalid), 32'd0);
    checkOutput("post_rst_done", 32'(ndone), 32'd0);
    applyStimulus('{1'b0, 32'h0, 16'd3, 32'h0, 5, 3, 0, 32'd6}, done_at, nvalid, nwr, sum);
    checkOutput("clean_done_cycle", 32'(done_at), 32'd5);
    checkOutput("clean_rdvalid_count", 32'(nvalid), 32'd3);
    checkOutput("clean_checksum", sum, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
